// File: rtl/trail_writer.sv
// trail_writer: sole driver of the frameRAM write port; clears the buffer to background,
// then on each frame tick paints TRAIL_H rows of trail words for each live bike.
module trail_writer #(
    parameter logic [3:0] BG_COLOR = 4'h0,
    parameter int         TRAIL_H  = 2,
    parameter int         H_WORDS  = 320,
    parameter int         V_ROWS   = 480
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        clear_req,
    input  logic [9:0]  Blue_X,
    input  logic [9:0]  Blue_Y,
    input  logic [9:0]  Red_X,
    input  logic [9:0]  Red_Y,
    input  logic        Blue_alive,
    input  logic        Red_alive,
    input  logic [3:0]  Blue_color,
    input  logic [3:0]  Red_color,
    output logic [18:0] write_address,
    output logic [15:0] Data_Out,
    output logic        WE,
    output logic        busy,
    output logic        ready
);
    localparam int          SW        = $clog2(2 * TRAIL_H + 1);
    localparam logic [18:0] LAST      = 19'(H_WORDS * V_ROWS - 1);
    localparam logic [18:0] HWL       = 19'(H_WORDS);
    localparam logic [10:0] XMAX      = 11'(2 * H_WORDS);
    localparam logic [10:0] YMAX      = 11'(V_ROWS);
    localparam logic [SW-1:0] TH      = SW'(TRAIL_H);
    localparam logic [SW-1:0] LAST_SLOT = SW'(2 * TRAIL_H - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, PAINT_B, PAINT_R} state_t;

    state_t        r_state, w_next;
    logic [18:0]   r_clr, w_clr_next;
    logic [SW-1:0] r_slot, w_slot_next;
    logic          r_s1, r_s2, r_s3;
    logic [9:0]    r_bx, r_by, r_rx, r_ry;
    logic          r_ba, r_ra;
    logic [3:0]    r_bc, r_rc;
    logic          w_tick, w_live, w_red, w_alive, w_ok, w_we, w_busy;
    logic [9:0]    w_x, w_y;
    logic [3:0]    w_color;
    logic [SW-1:0] w_row;
    logic [10:0]   w_yr;
    logic [18:0]   w_paddr, w_addr;
    logic [15:0]   w_data;

    assign w_tick = r_s2 & ~r_s3;
    // The first blue slot is issued at the tick edge itself, so it reads the live inputs.
    assign w_live  = r_state == IDLE;
    assign w_red   = r_state == PAINT_R;
    assign w_x     = w_live ? Blue_X     : (w_red ? r_rx : r_bx);
    assign w_y     = w_live ? Blue_Y     : (w_red ? r_ry : r_by);
    assign w_alive = w_live ? Blue_alive : (w_red ? r_ra : r_ba);
    assign w_color = w_live ? Blue_color : (w_red ? r_rc : r_bc);
    assign w_row   = w_red ? r_slot - TH : (w_live ? '0 : r_slot);
    assign w_yr    = {1'b0, w_y} + 11'(w_row);
    assign w_ok    = w_alive && ({1'b0, w_x} < XMAX) && (w_yr < YMAX);
    assign w_paddr = 19'(w_yr) * HWL + 19'(w_x[9:1]);

    always_comb begin
        w_next      = r_state;
        w_clr_next  = r_clr;
        w_slot_next = r_slot;
        w_we        = 1'b0;
        w_busy      = 1'b0;
        w_addr      = w_paddr;
        w_data      = {4'h0, w_color, 4'h0, w_color};
        if (clear_req || r_state == CLEAR) begin
            w_addr     = clear_req ? '0 : r_clr;
            w_data     = {4'h0, BG_COLOR, 4'h0, BG_COLOR};
            w_we       = 1'b1;
            w_busy     = 1'b1;
            w_clr_next = w_addr + 19'd1;
            w_next     = (w_addr == LAST) ? IDLE : CLEAR;
        end else if (r_state == IDLE) begin
            if (w_tick) begin
                w_we        = w_ok;
                w_busy      = 1'b1;
                w_slot_next = SW'(1);
                w_next      = (TRAIL_H > 1) ? PAINT_B : PAINT_R;
            end
        end else begin
            w_we        = w_ok;
            w_busy      = 1'b1;
            w_slot_next = r_slot + SW'(1);
            w_next      = (r_slot == LAST_SLOT) ? IDLE : (w_slot_next < TH) ? PAINT_B : PAINT_R;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state       <= CLEAR;
            r_clr         <= '0;
            r_slot        <= '0;
            {r_s3, r_s2, r_s1} <= 3'b000;
            WE            <= 1'b0;
            write_address <= '0;
            Data_Out      <= '0;
            busy          <= 1'b0;
            ready         <= 1'b0;
        end else begin
            {r_s3, r_s2, r_s1} <= {r_s2, r_s1, frame_clk};
            r_state       <= w_next;
            r_clr         <= w_clr_next;
            r_slot        <= w_slot_next;
            WE            <= w_we;
            write_address <= w_addr;
            Data_Out      <= w_data;
            busy          <= w_busy;
            ready         <= (r_state != CLEAR) && !clear_req;
        end
    end

    always_ff @(posedge Clk) begin
        if (r_state == IDLE && w_tick && !clear_req) begin
            {r_bx, r_by, r_ba, r_bc} <= {Blue_X, Blue_Y, Blue_alive, Blue_color};
            {r_rx, r_ry, r_ra, r_rc} <= {Red_X, Red_Y, Red_alive, Red_color};
        end
    end
endmodule

// File: tb/tb_trail_writer.sv
// tb_trail_writer: directed and randomized frames checked against a slot-list model of the
// trail rules; the buffer is shrunk to 16 rows so each full clear stays short.
module tb_trail_writer;
    localparam int         T    = 2;
    localparam int         HW   = 320;
    localparam int         VR   = 16;
    localparam logic [3:0] BG   = 4'h5;
    localparam int         NCLR = HW * VR;

    logic        Clk = 1'b0;
    logic        Reset, frame_clk, clear_req;
    logic [9:0]  Blue_X, Blue_Y, Red_X, Red_Y;
    logic        Blue_alive, Red_alive;
    logic [3:0]  Blue_color, Red_color;
    logic [18:0] write_address;
    logic [15:0] Data_Out;
    logic        WE, busy, ready;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    trail_writer #(.BG_COLOR(BG), .TRAIL_H(T), .H_WORDS(HW), .V_ROWS(VR)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .clear_req(clear_req),
        .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
        .Blue_alive(Blue_alive), .Red_alive(Red_alive),
        .Blue_color(Blue_color), .Red_color(Red_color),
        .write_address(write_address), .Data_Out(Data_Out),
        .WE(WE), .busy(busy), .ready(ready)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expects the next edge to issue address 0; checks len clear cycles, then the idle tail.
    task automatic check_clear(input bit fc_mid, input int len);
        int bad = -1;
        int loud = 0;
        for (int i = 0; i < len; i++) begin
            step();
            clear_req = 1'b0;
            if (fc_mid && i == 100) frame_clk = 1'b1;
            if (bad < 0 && !(WE === 1'b1 && write_address === 19'(i) &&
                Data_Out === {4'h0, BG, 4'h0, BG} && busy === 1'b1 && ready === 1'b0))
                bad = i;
        end
        check("clear_first_bad", 32'(bad), 32'hFFFF_FFFF);
        if (len == NCLR) begin
            step();
            check("clear_done_ready", 32'(ready), 32'd1);
            check("clear_done_busy", 32'(busy), 32'd0);
            check("clear_done_we", 32'(WE), 32'd0);
            for (int i = 0; i < 8; i++) begin
                step();
                if (WE !== 1'b0 || busy !== 1'b0) loud++;
            end
            check("idle_quiet", 32'(loud), 32'd0);
            frame_clk = 1'b0;
            repeat (3) step();
        end
    endtask

    // abort_at >= 0 stops after that slot with a clear_req pulse (or a reset when abort_rst).
    task automatic paint(input logic [9:0] bx, input logic [9:0] by, input logic ba, input logic [3:0] bc,
                         input logic [9:0] rx, input logic [9:0] ry, input logic ra, input logic [3:0] rc,
                         input int abort_at, input bit abort_rst);
        int xs[2], ys[2], cs[2], yr;
        bit as[2], ok;
        xs[0] = int'(bx); ys[0] = int'(by); as[0] = ba; cs[0] = int'(bc);
        xs[1] = int'(rx); ys[1] = int'(ry); as[1] = ra; cs[1] = int'(rc);
        {Blue_X, Blue_Y, Blue_alive, Blue_color} = {bx, by, ba, bc};
        {Red_X, Red_Y, Red_alive, Red_color} = {rx, ry, ra, rc};
        frame_clk = 1'b1;
        step();
        check("pre_we0", 32'(WE), 32'd0);
        step();
        check("pre_we1", 32'(WE), 32'd0);
        check("pre_busy", 32'(busy), 32'd0);
        for (int s = 0; s < 2 * T; s++) begin
            step();
            if (s == 0) begin
                {Blue_X, Blue_Y, Red_X, Red_Y} = 40'($urandom) ^ {8'h0, 32'($urandom)};
                {Blue_alive, Red_alive, Blue_color, Red_color} = 10'($urandom);
            end
            yr = ys[s / T] + s % T;
            ok = as[s / T] && xs[s / T] < 2 * HW && yr < VR;
            check("slot_we", 32'(WE), 32'(ok));
            check("slot_busy", 32'(busy), 32'd1);
            check("slot_ready", 32'(ready), 32'd1);
            if (ok) begin
                check("slot_addr", 32'(write_address), 32'(yr * HW + xs[s / T] / 2));
                check("slot_data", 32'(Data_Out), 32'(cs[s / T] * 257));
            end
            if (s == abort_at) begin
                if (abort_rst) begin
                    Reset = 1'b0;
                    step();
                    check("rst_outs", {WE, busy, ready, Data_Out, 13'(write_address)}, 32'd0);
                    check("rst_addr_hi", 32'(write_address), 32'd0);
                    step();
                    Reset = 1'b1;
                    frame_clk = 1'b0;
                end else begin
                    clear_req = 1'b1;
                end
                return;
            end
        end
        step();
        check("post_we", 32'(WE), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        frame_clk = 1'b0;
        repeat (3) step();
        check("post_idle_we", 32'(WE), 32'd0);
    endtask

    initial begin
        Reset = 1'b0; frame_clk = 1'b0; clear_req = 1'b0;
        {Blue_X, Blue_Y, Red_X, Red_Y} = '0;
        {Blue_alive, Red_alive, Blue_color, Red_color} = '0;
        step();
        step();
        check("reset_we", 32'(WE), 32'd0);
        check("reset_addr", 32'(write_address), 32'd0);
        check("reset_data", 32'(Data_Out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        Reset = 1'b1;
        check_clear(1'b0, NCLR);

        paint(10'd100, 10'd5, 1'b1, 4'h8, 10'd300, 10'd10, 1'b1, 4'h2, -1, 1'b0);
        paint(10'd101, 10'd15, 1'b1, 4'h3, 10'd0, 10'd14, 1'b1, 4'hF, -1, 1'b0);
        paint(10'd639, 10'd0, 1'b1, 4'h6, 10'd640, 10'd3, 1'b1, 4'h9, -1, 1'b0);
        paint(10'd44, 10'd7, 1'b1, 4'hA, 10'd45, 10'd7, 1'b0, 4'hB, -1, 1'b0);
        paint(10'd1023, 10'd1023, 1'b1, 4'h1, 10'd2, 10'd16, 1'b1, 4'h4, -1, 1'b0);
        for (int k = 0; k < 25; k++)
            paint(10'($urandom_range(0, 700)), 10'($urandom_range(0, VR + 2)), $urandom_range(0, 3) != 0,
                  4'($urandom), 10'($urandom_range(0, 700)), 10'($urandom_range(0, VR + 2)),
                  $urandom_range(0, 3) != 0, 4'($urandom), -1, 1'b0);

        paint(10'd200, 10'd2, 1'b1, 4'hC, 10'd400, 10'd4, 1'b1, 4'hD, 0, 1'b0);
        check_clear(1'b0, 300);
        clear_req = 1'b1;
        check_clear(1'b1, NCLR);

        frame_clk = 1'b1;
        step();
        step();
        clear_req = 1'b1;
        check_clear(1'b0, NCLR);

        paint(10'd50, 10'd1, 1'b1, 4'h7, 10'd60, 10'd2, 1'b1, 4'hE, -1, 1'b0);
        paint(10'd300, 10'd9, 1'b1, 4'h2, 10'd310, 10'd11, 1'b1, 4'h6, 1, 1'b1);
        check_clear(1'b0, NCLR);
        paint(10'd5, 10'd8, 1'b1, 4'h9, 10'd7, 10'd8, 1'b1, 4'h3, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
